pic_line_packer: RTL and testbench
==================================

Name: pic_line_packer

Overview:
- Upstream feeder for the SRAM line-buffer / reg-array stage.
- Accepts a narrow picture word stream and packs RATIO = DW/IW words into each DW-bit beat.
- Frames each picture for the downstream stage with a DATA_SOP pulse, DATA beats gated by WREADY, and one DATA_HSYNC pulse per line.
- A picture is PIC_SIZE lines of PIC_SIZE beats each.

Parameters:
- IW, 32, input word width.
- DW, 128, output beat width; DW must be an integer multiple of IW.
- FD, 4, output FIFO depth in beats; must be a power of 2, minimum 2.

Ports:
- SYS_CLK  in  1  clock.
- SYS_RST  in  1  reset; synchronous, active-high.
- START  in  1  pulse; begins a picture. Honoured only in IDLE with PIC_SIZE != 0.
- PIC_SIZE  in  8  beats per line and lines per picture; sampled on an honoured START.
- S_DATA  in  IW  input word.
- S_VLD  in  1  input word valid.
- S_RDY  out  1  word accepted when S_VLD & S_RDY.
- DATA  out  DW  output beat (FIFO head).
- DATA_VLD  out  1  beat valid.
- WREADY  in  1  downstream ready; a beat transfers when DATA_VLD & WREADY.
- DATA_SOP  out  1  one-cycle picture-start pulse.
- DATA_HSYNC  out  1  one-cycle end-of-line pulse.
- BUSY  out  1  high whenever state != IDLE.
- PIC_DONE  out  1  one-cycle pulse when a picture completes.

Behaviour:
- Reset: synchronous on SYS_RST=1. It overrides everything, including reset mid-picture.
  - All outputs reset to 0.
  - FIFO emptied; packer word count, beat count, line count and quota count cleared; FSM forced to IDLE.
  - Partial words are discarded.
- FSM states:
  - IDLE: waits for an honoured START, then latches PIC_SIZE and goes to SOP. START with PIC_SIZE=0 is ignored.
  - SOP: DATA_SOP=1 for exactly 1 cycle, DATA_VLD=0; next state STREAM.
  - STREAM: DATA_VLD = !fifo_empty. After the beat with beat_cnt == PIC_SIZE-1 transfers, clear beat_cnt and go to HSYNC.
  - HSYNC: DATA_HSYNC=1 for 1 cycle, DATA_VLD=0. If line_cnt == PIC_SIZE-1, go to DONE; otherwise increment line_cnt and go to STREAM.
  - DONE: PIC_DONE=1 for 1 cycle; next state IDLE.
- START outside IDLE is ignored.
- Input side:
  - S_RDY = BUSY & !fifo_full & (quota_cnt < PIC_SIZE*PIC_SIZE*RATIO).
  - quota_cnt is 18 bits.
  - Input acceptance is independent of output state, so input may run ahead into the FIFO, including across a line boundary and during the HSYNC cycle.
- Packing:
  - Word k of a beat (k = 0..RATIO-1) lands in DATA[k*IW +: IW], i.e. the first word is in the LSBs.
  - On acceptance of word RATIO-1, the assembled beat is pushed to the FIFO at the same clock edge.
  - S_RDY is already low when the FIFO is full, so a push never overflows.
- Latency: with WREADY=1 and the FIFO empty, the last word of a beat accepted at cycle t gives DATA_VLD=1 at cycle t+1.
- Output hold: while DATA_VLD & !WREADY, DATA and DATA_VLD stay stable.
- DATA_VLD is never asserted in IDLE, SOP, HSYNC or DONE.
- Simultaneous FIFO push and pop in the same cycle is allowed. Occupancy is unchanged, including when the FIFO is full or holds 1 entry.
- Pointers are log2(FD) bits and wrap naturally; a separate count of log2(FD)+1 bits distinguishes full from empty.
- Picture totals: exactly PIC_SIZE DATA_HSYNC pulses and PIC_SIZE*PIC_SIZE beats per picture. The last HSYNC precedes PIC_DONE by 1 cycle.

Test Plan:
- Reset, then PIC_SIZE=2, START, input words 1..16 continuous, WREADY=1.
  - Response: SOP 1 cycle, then beats 0x00000004_00000003_00000002_00000001 and 0x…08_07_06_05, HSYNC, beats 0x…0C_0B_0A_09 and 0x…10_0F_0E_0D, HSYNC, PIC_DONE.
  - Word 17 is not accepted (S_RDY=0).
- PIC_SIZE=3, WREADY=0 throughout.
  - Response: exactly 4 beats (16 words) accepted, then S_RDY=0 and DATA/DATA_VLD stable on beat 0.
  - Releasing WREADY drains all 9 beats with 3 HSYNC pulses.
- WREADY toggling 1/0 every cycle, PIC_SIZE=4.
  - Response: 16 beats in order, no duplicates, HSYNC after beats 4, 8, 12 and 16, each with DATA_VLD=0 in that cycle.
- START with PIC_SIZE=0 → stays IDLE, BUSY=0, S_RDY=0, no DATA_SOP.
- START pulsed again mid-picture → ignored; the picture completes normally with the original PIC_SIZE.
- SYS_RST=1 for 1 cycle mid-line (2 words into a beat, FIFO holding 3 beats).
  - Response: next cycle all outputs are 0 and BUSY=0.
  - A following START produces a clean picture with no stale beats.

Source files
------------

// File: rtl/pic_line_packer.sv
// -----------------------------------------------------------------------------
// pic_line_packer
//
// Upstream feeder for the SRAM line-buffer / reg-array stage. Narrow IW-bit
// picture words are packed RATIO = DW/IW at a time into DW-bit beats. The
// first word of a beat lands in the LSBs. Beats are queued in a small FIFO
// and are then framed for the downstream stage:
//
//   SOP pulse -> { PIC_SIZE beats -> HSYNC pulse } x PIC_SIZE -> PIC_DONE
//
// Input acceptance does not depend on the output framing. Words can run ahead
// into the FIFO, across line boundaries and through HSYNC cycles. A quota
// counter stops intake once the whole picture has been received.
//
// Ports
//   SYS_CLK     in   1    clock
//   SYS_RST     in   1    synchronous active-high reset
//   START       in   1    begin picture (honoured in IDLE with PIC_SIZE != 0)
//   PIC_SIZE    in   8    beats per line and lines per picture
//   S_DATA      in   IW   input word
//   S_VLD       in   1    input word valid
//   S_RDY       out  1    input word accepted when S_VLD & S_RDY
//   DATA        out  DW   output beat (FIFO head, zero when FIFO empty)
//   DATA_VLD    out  1    output beat valid
//   WREADY      in   1    downstream ready
//   DATA_SOP    out  1    one-cycle picture start pulse
//   DATA_HSYNC  out  1    one-cycle end-of-line pulse
//   BUSY        out  1    high whenever the FSM is not IDLE
//   PIC_DONE    out  1    one-cycle picture complete pulse
// -----------------------------------------------------------------------------
module pic_line_packer #(
    parameter int IW = 32,
    parameter int DW = 128,
    parameter int FD = 4
) (
    input  logic          SYS_CLK,
    input  logic          SYS_RST,
    input  logic          START,
    input  logic [7:0]    PIC_SIZE,
    input  logic [IW-1:0] S_DATA,
    input  logic          S_VLD,
    output logic          S_RDY,
    output logic [DW-1:0] DATA,
    output logic          DATA_VLD,
    input  logic          WREADY,
    output logic          DATA_SOP,
    output logic          DATA_HSYNC,
    output logic          BUSY,
    output logic          PIC_DONE
);

    localparam int RATIO = DW / IW;
    localparam int WCW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int AW    = (FD > 1) ? $clog2(FD) : 1;

    // -------------------------------------------------------------------------
    // FSM declarations
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SOP    = 3'd1,
        ST_STREAM = 3'd2,
        ST_HSYNC  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t      state_reg,    state_next;
    logic [7:0]  size_reg,     size_next;
    logic [7:0]  beat_cnt_reg, beat_cnt_next;
    logic [7:0]  line_cnt_reg, line_cnt_next;

    logic        start_pic;
    logic        sop;
    logic        hsync;
    logic        done;
    logic        data_vld;
    logic        pop;

    // -------------------------------------------------------------------------
    // Input / packer declarations
    // -------------------------------------------------------------------------
    logic [17:0]    quota_cnt_reg;
    logic [31:0]    quota_limit;
    logic           quota_ok;
    logic           busy;
    logic           s_rdy;
    logic           accept;
    logic           last_word;
    logic           push;
    logic [WCW-1:0] word_cnt_reg;
    logic [IW-1:0]  pack_reg [RATIO];
    logic [DW-1:0]  push_beat;

    // -------------------------------------------------------------------------
    // FIFO declarations
    // -------------------------------------------------------------------------
    logic [DW-1:0]  fifo_mem [FD];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           fifo_empty;
    logic           fifo_full;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == (AW+1)'(FD));

    // -------------------------------------------------------------------------
    // Input side
    // -------------------------------------------------------------------------
    assign busy = (state_reg != ST_IDLE);

    // Total words in one picture. This is evaluated 32 bits wide, so it cannot
    // overflow for any PIC_SIZE or RATIO.
    assign quota_limit = 32'(size_reg) * 32'(size_reg) * 32'(RATIO);
    assign quota_ok    = ({14'd0, quota_cnt_reg} < quota_limit);

    assign s_rdy     = busy & ~fifo_full & quota_ok;
    assign accept    = S_VLD & s_rdy;
    assign last_word = (word_cnt_reg == WCW'(RATIO - 1));
    // The FIFO is never full here because s_rdy already excludes that case.
    assign push      = accept & last_word;

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            quota_cnt_reg <= '0;
            word_cnt_reg  <= '0;
        end else if (start_pic) begin
            quota_cnt_reg <= '0;
            word_cnt_reg  <= '0;
        end else if (accept) begin
            quota_cnt_reg <= quota_cnt_reg + 18'd1;
            word_cnt_reg  <= last_word ? '0 : word_cnt_reg + WCW'(1);
        end
    end

    // Per-lane word capture. The lane that matches the current word count
    // takes the incoming word. While the last word is being accepted, that
    // word goes straight into push_beat, so the beat enters the FIFO on the
    // same edge. Stale lane contents never leak: every lane is rewritten
    // before the next push.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            logic lane_sel;
            assign lane_sel = (word_cnt_reg == WCW'(gi));

            always_ff @(posedge SYS_CLK) begin
                if (accept && lane_sel) begin
                    pack_reg[gi] <= S_DATA;
                end
            end

            assign push_beat[gi*IW +: IW] = lane_sel ? S_DATA : pack_reg[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Beat FIFO
    // The head must be visible in the cycle after a push, so reads are
    // combinational. The storage is tiny, so distributed memory suits it.
    // -------------------------------------------------------------------------
    always_ff @(posedge SYS_CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_beat;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            // A push and a pop in the same cycle leave the occupancy unchanged.
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output framing FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            state_reg    <= ST_IDLE;
            size_reg     <= '0;
            beat_cnt_reg <= '0;
            line_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            size_reg     <= size_next;
            beat_cnt_reg <= beat_cnt_next;
            line_cnt_reg <= line_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        size_next     = size_reg;
        beat_cnt_next = beat_cnt_reg;
        line_cnt_next = line_cnt_reg;
        start_pic     = 1'b0;
        sop           = 1'b0;
        hsync         = 1'b0;
        done          = 1'b0;
        data_vld      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (START && (PIC_SIZE != 8'd0)) begin
                    start_pic     = 1'b1;
                    size_next     = PIC_SIZE;
                    beat_cnt_next = '0;
                    line_cnt_next = '0;
                    state_next    = ST_SOP;
                end
            end

            ST_SOP: begin
                sop        = 1'b1;
                state_next = ST_STREAM;
            end

            ST_STREAM: begin
                data_vld = ~fifo_empty;
                if (~fifo_empty && WREADY) begin
                    if (beat_cnt_reg == size_reg - 8'd1) begin
                        beat_cnt_next = '0;
                        state_next    = ST_HSYNC;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 8'd1;
                    end
                end
            end

            ST_HSYNC: begin
                hsync = 1'b1;
                if (line_cnt_reg == size_reg - 8'd1) begin
                    line_cnt_next = '0;
                    state_next    = ST_DONE;
                end else begin
                    line_cnt_next = line_cnt_reg + 8'd1;
                    state_next    = ST_STREAM;
                end
            end

            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign pop = data_vld & WREADY;

    // -------------------------------------------------------------------------
    // Outputs
    // DATA is masked while the FIFO is empty. The bus therefore reads zero
    // after reset, and never shows memory contents that were never written.
    // -------------------------------------------------------------------------
    assign S_RDY      = s_rdy;
    assign DATA       = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
    assign DATA_VLD   = data_vld;
    assign DATA_SOP   = sop;
    assign DATA_HSYNC = hsync;
    assign BUSY       = busy;
    assign PIC_DONE   = done;

endmodule

// File: tb/tb_pic_line_packer.sv
// -----------------------------------------------------------------------------
// tb_pic_line_packer
//
// Directed testbench for pic_line_packer (IW=32, DW=128, FD=4). A negedge
// monitor logs every beat transfer and every SOP/HSYNC/DONE pulse into counts
// and signatures. Directed scenarios then compare those logs with
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_pic_line_packer;

    logic         SYS_CLK  = 1'b0;
    logic         SYS_RST  = 1'b1;
    logic         START    = 1'b0;
    logic [7:0]   PIC_SIZE = 8'd0;
    logic [31:0]  S_DATA   = 32'd0;
    logic         S_VLD    = 1'b0;
    logic         S_RDY;
    logic [127:0] DATA;
    logic         DATA_VLD;
    logic         WREADY   = 1'b1;
    logic         DATA_SOP;
    logic         DATA_HSYNC;
    logic         BUSY;
    logic         PIC_DONE;

    pic_line_packer #(.IW(32), .DW(128), .FD(4)) dut (
        .SYS_CLK    (SYS_CLK),
        .SYS_RST    (SYS_RST),
        .START      (START),
        .PIC_SIZE   (PIC_SIZE),
        .S_DATA     (S_DATA),
        .S_VLD      (S_VLD),
        .S_RDY      (S_RDY),
        .DATA       (DATA),
        .DATA_VLD   (DATA_VLD),
        .WREADY     (WREADY),
        .DATA_SOP   (DATA_SOP),
        .DATA_HSYNC (DATA_HSYNC),
        .BUSY       (BUSY),
        .PIC_DONE   (PIC_DONE)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    // ---------------------------------------------------------------- checking
    int n_chk = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // Beat whose first (LSB) word is b, followed by b+1, b+2, b+3.
    function automatic logic [127:0] exp_beat(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    // ---------------------------------------------------------------- monitor
    logic         clr_req = 1'b0;
    int           cyc = 0;
    int           acc_cnt = 0;
    int           acc4_cyc = 0;
    int           first_vld_cyc = -1;
    int           n_sop = 0;
    int           n_hs = 0;
    int           n_done = 0;
    int           hs_cyc = 0;
    int           done_cyc = 0;
    int           vld_bad = 0;
    int           hold_bad = 0;
    logic [63:0]  ev_sig = '0;
    logic [63:0]  hs_at_sig = '0;
    logic [127:0] beats [$];
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data = '0;

    initial begin
        forever begin
            @(negedge SYS_CLK);
            cyc++;
            if (clr_req) begin
                acc_cnt = 0; acc4_cyc = 0; first_vld_cyc = -1;
                n_sop = 0; n_hs = 0; n_done = 0; hs_cyc = 0; done_cyc = 0;
                vld_bad = 0; hold_bad = 0; ev_sig = '0; hs_at_sig = '0;
                beats.delete();
                prev_stall = 1'b0;
            end
            if (S_VLD && S_RDY) begin
                acc_cnt++;
                if (acc_cnt == 4) acc4_cyc = cyc;
            end
            if (DATA_VLD && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (DATA_VLD && WREADY) begin
                beats.push_back(DATA);
                ev_sig = {ev_sig[59:0], 4'h4};
            end
            if (DATA_SOP) begin
                n_sop++;
                ev_sig = {ev_sig[59:0], 4'h1};
                if (DATA_VLD) vld_bad++;
            end
            if (DATA_HSYNC) begin
                n_hs++;
                hs_cyc = cyc;
                hs_at_sig = {hs_at_sig[55:0], 8'(beats.size())};
                ev_sig = {ev_sig[59:0], 4'h2};
                if (DATA_VLD) vld_bad++;
            end
            if (PIC_DONE) begin
                n_done++;
                done_cyc = cyc;
                ev_sig = {ev_sig[59:0], 4'h3};
                if (DATA_VLD) vld_bad++;
            end
            if (!BUSY && DATA_VLD) vld_bad++;
            if (prev_stall && (!DATA_VLD || DATA !== prev_data)) hold_bad++;
            prev_stall = DATA_VLD && !WREADY && !SYS_RST;
            prev_data  = DATA;
        end
    end

    // ------------------------------------------------------- WREADY driver
    // 0: always ready, 1: never ready, 2: toggle every cycle
    int wr_mode = 0;

    initial begin
        forever begin
            @(posedge SYS_CLK);
            #1;
            case (wr_mode)
                1:       WREADY = 1'b0;
                2:       WREADY = ~WREADY;
                default: WREADY = 1'b1;
            endcase
        end
    end

    // ---------------------------------------------------------------- tasks
    task automatic clear_logs();
        clr_req = 1'b1;
        @(negedge SYS_CLK);
        #1;
        clr_req = 1'b0;
    endtask

    task automatic start_pic(input logic [7:0] size);
        PIC_SIZE = size;
        START    = 1'b1;
        @(posedge SYS_CLK);
        #1;
        START    = 1'b0;
    endtask

    task automatic feed(input int n, input logic [31:0] first);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            S_VLD  = 1'b1;
            S_DATA = first + 32'(i);
            forever begin
                @(negedge SYS_CLK);
                if (S_RDY) begin
                    @(posedge SYS_CLK);
                    #1;
                    break;
                end
                t++;
                if (t > 2000) begin
                    check_val("feed_timeout", 128'(i), 128'(n));
                    S_VLD = 1'b0;
                    return;
                end
                @(posedge SYS_CLK);
                #1;
            end
        end
        S_VLD = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (n_done == 0 && t < 2000) begin
            @(posedge SYS_CLK);
            #2;
            t++;
        end
        check_val(tag, 128'(n_done), 128'd1);
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- main
    initial begin
        // Reset state
        repeat (2) @(posedge SYS_CLK);
        @(negedge SYS_CLK);
        check_val("rst_busy",  128'(BUSY), 128'd0);
        check_val("rst_ctrl",  128'({S_RDY, DATA_VLD, DATA_SOP, DATA_HSYNC, PIC_DONE}), 128'd0);
        check_val("rst_data",  DATA, 128'd0);
        @(posedge SYS_CLK);
        #1;
        SYS_RST = 1'b0;
        @(posedge SYS_CLK);
        #1;

        // T1: PIC_SIZE=2, words 1..16, WREADY=1
        clear_logs();
        start_pic(8'd2);
        feed(16, 32'd1);
        S_VLD  = 1'b1;
        S_DATA = 32'd17;
        @(negedge SYS_CLK);
        check_val("t1_rdy_after_quota", 128'(S_RDY), 128'd0);
        wait_done("t1_done");
        S_VLD = 1'b0;
        check_val("t1_accepted", 128'(acc_cnt), 128'd16);
        check_val("t1_events", 128'(ev_sig), 128'h14424423);
        check_val("t1_nbeats", 128'(beats.size()), 128'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < beats.size())
                check_val($sformatf("t1_beat%0d", i), beats[i], exp_beat(32'(1 + 4 * i)));
        end
        check_val("t1_latency", 128'(first_vld_cyc - acc4_cyc), 128'd1);
        check_val("t1_hs_to_done", 128'(done_cyc - hs_cyc), 128'd1);
        check_val("t1_vld_gating", 128'(vld_bad), 128'd0);
        @(negedge SYS_CLK);
        check_val("t1_idle_busy", 128'(BUSY), 128'd0);

        // T2: PIC_SIZE=3, WREADY held low, then released
        wr_mode = 1;
        @(posedge SYS_CLK);
        #2;
        clear_logs();
        start_pic(8'd3);
        fork
            feed(36, 32'd1);
            begin
                repeat (30) @(negedge SYS_CLK);
                check_val("t2_accepted_stalled", 128'(acc_cnt), 128'd16);
                check_val("t2_rdy_full", 128'(S_RDY), 128'd0);
                check_val("t2_vld_held", 128'(DATA_VLD), 128'd1);
                check_val("t2_data_held", DATA, exp_beat(32'd1));
                check_val("t2_hold_stable", 128'(hold_bad), 128'd0);
                wr_mode = 0;
            end
        join
        wait_done("t2_done");
        check_val("t2_nbeats", 128'(beats.size()), 128'd9);
        check_val("t2_nhsync", 128'(n_hs), 128'd3);
        for (int i = 0; i < 9; i++) begin
            if (i < beats.size())
                check_val($sformatf("t2_beat%0d", i), beats[i], exp_beat(32'(1 + 4 * i)));
        end

        // T3: PIC_SIZE=4, WREADY toggling
        clear_logs();
        wr_mode = 2;
        start_pic(8'd4);
        feed(64, 32'h100);
        wait_done("t3_done");
        wr_mode = 0;
        check_val("t3_nbeats", 128'(beats.size()), 128'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < beats.size())
                check_val($sformatf("t3_beat%0d", i), beats[i], exp_beat(32'(32'h100 + 4 * i)));
        end
        check_val("t3_hsync_pos", 128'(hs_at_sig), 128'h04080C10);
        check_val("t3_vld_gating", 128'(vld_bad), 128'd0);

        // T4: START with PIC_SIZE=0 is ignored
        @(posedge SYS_CLK);
        #1;
        clear_logs();
        S_VLD  = 1'b1;
        S_DATA = 32'hDEAD;
        start_pic(8'd0);
        repeat (3) @(negedge SYS_CLK);
        check_val("t4_busy", 128'(BUSY), 128'd0);
        check_val("t4_rdy", 128'(S_RDY), 128'd0);
        check_val("t4_nsop", 128'(n_sop), 128'd0);
        S_VLD = 1'b0;
        @(posedge SYS_CLK);
        #1;

        // T5: START pulsed again mid-picture
        clear_logs();
        start_pic(8'd2);
        fork
            feed(16, 32'h200);
            begin
                repeat (6) @(posedge SYS_CLK);
                #1;
                PIC_SIZE = 8'd5;
                START    = 1'b1;
                @(posedge SYS_CLK);
                #1;
                START    = 1'b0;
            end
        join
        wait_done("t5_done");
        check_val("t5_nsop", 128'(n_sop), 128'd1);
        check_val("t5_events", 128'(ev_sig), 128'h14424423);
        check_val("t5_nbeats", 128'(beats.size()), 128'd4);
        if (beats.size() > 3)
            check_val("t5_last_beat", beats[3], exp_beat(32'h20C));
        @(negedge SYS_CLK);
        check_val("t5_idle_busy", 128'(BUSY), 128'd0);

        // T6: reset mid-line with three beats queued and two words pending
        wr_mode = 1;
        @(posedge SYS_CLK);
        #2;
        start_pic(8'd4);
        feed(14, 32'h300);
        @(negedge SYS_CLK);
        check_val("t6_pre_vld", 128'(DATA_VLD), 128'd1);
        @(posedge SYS_CLK);
        #1;
        SYS_RST = 1'b1;
        @(posedge SYS_CLK);
        #1;
        SYS_RST = 1'b0;
        @(negedge SYS_CLK);
        check_val("t6_post_ctrl", 128'({BUSY, S_RDY, DATA_VLD, DATA_SOP, DATA_HSYNC, PIC_DONE}), 128'd0);
        check_val("t6_post_data", DATA, 128'd0);
        wr_mode = 0;
        clear_logs();
        start_pic(8'd1);
        feed(4, 32'h400);
        wait_done("t6_done");
        check_val("t6_events", 128'(ev_sig), 128'h1423);
        check_val("t6_nbeats", 128'(beats.size()), 128'd1);
        if (beats.size() > 0)
            check_val("t6_clean_beat", beats[0], exp_beat(32'h400));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
